// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if
//   Control and output bundle for the clock-divider bank.
//   Signals:
//     i_clk_en     [NUM_CH]           per-channel divider enable
//     i_div_ratio  [NUM_CH*RATIO_WD]  packed ratios, channel k at [k*RATIO_WD +: RATIO_WD]
//     i_ratio_load [NUM_CH]           single-cycle strobe capturing that channel's ratio slice
//     o_div_clk    [NUM_CH]           divided clock (reference clock when bypassed)
//     o_rise_tick  [NUM_CH]           one-cycle strobe in the cycle o_div_clk rises
//     o_ratio_busy [NUM_CH]           a loaded ratio waits for the next period boundary
//   Modports: master drives the controls, slave is the divider bank.
interface clk_div_bank_if #(
  parameter int NUM_CH   = 2,
  parameter int RATIO_WD = 8
);
  logic [NUM_CH-1:0]          i_clk_en;
  logic [NUM_CH*RATIO_WD-1:0] i_div_ratio;
  logic [NUM_CH-1:0]          i_ratio_load;
  logic [NUM_CH-1:0]          o_div_clk;
  logic [NUM_CH-1:0]          o_rise_tick;
  logic [NUM_CH-1:0]          o_ratio_busy;

  modport master (
    output i_clk_en, i_div_ratio, i_ratio_load,
    input  o_div_clk, o_rise_tick, o_ratio_busy
  );

  modport slave (
    input  i_clk_en, i_div_ratio, i_ratio_load,
    output o_div_clk, o_rise_tick, o_ratio_busy
  );
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   NUM_CH independent, run-time reprogrammable integer dividers of i_ref_clk.
//   A new ratio is held in a shadow register and applied only at a period
//   boundary, so reprogramming never shortens a high or low phase.
//   Ports:
//     i_ref_clk  reference clock, all state on its rising edge
//     i_rst      asynchronous active-low reset
//     bus        clk_div_bank_if slave (enables, ratios, loads / clocks, ticks, busy)
module clk_div_bank #(
  parameter int NUM_CH   = 2,
  parameter int RATIO_WD = 8
) (
  input  logic          i_ref_clk,
  input  logic          i_rst,
  clk_div_bank_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [RATIO_WD-1:0] MIN_RUN = RATIO_WD'(2);
  localparam logic [RATIO_WD:0]   ONE_W   = (RATIO_WD+1)'(1);

  logic [NUM_CH-1:0] div_clk_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] busy_w;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e              state_q, state_d;
    logic [RATIO_WD-1:0] ratio_q, ratio_d;
    logic [RATIO_WD-1:0] shadow_q, shadow_d;
    logic [RATIO_WD-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                div_q, div_d;
    logic                tick_q, tick_d;

    logic [RATIO_WD-1:0] slice;
    logic                en, load, run, wrap;
    logic [RATIO_WD:0]   half, cnt_inc;

    assign slice = bus.i_div_ratio[k*RATIO_WD +: RATIO_WD];
    assign en    = bus.i_clk_en[k];
    assign load  = bus.i_ratio_load[k];
    assign run   = en && (ratio_q >= MIN_RUN);

    // One extra bit so R = 2^RATIO_WD-1 cannot overflow; odd ratios get
    // the longer phase high.
    assign half    = ({1'b0, ratio_q} + ONE_W) >> 1;
    assign cnt_inc = {1'b0, cnt_q} + ONE_W;
    assign wrap    = (cnt_inc == {1'b0, ratio_q});

    always_comb begin
      state_d  = state_q;
      ratio_d  = ratio_q;
      shadow_d = shadow_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      tick_d   = 1'b0;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          div_d = 1'b0;
          // Nothing is running, so a load takes effect at once.
          if (load) ratio_d = slice;
          // First high phase starts on the very edge run is seen.
          if (run) begin
            state_d = RUN;
            div_d   = 1'b1;
            tick_d  = 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            // Abort: drop to bypass and settle any pending ratio.
            state_d = IDLE;
            cnt_d   = '0;
            div_d   = 1'b0;
            if (load)        ratio_d = slice;
            else if (busy_q) ratio_d = shadow_q;
            busy_d  = 1'b0;
          end else if (wrap) begin
            // Period boundary: the only place the active ratio may change.
            // A load arriving now is newer than the shadow and wins.
            if (load)        ratio_d = slice;
            else if (busy_q) ratio_d = shadow_q;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (ratio_d >= MIN_RUN) begin
              div_d  = 1'b1;
              tick_d = 1'b1;
            end else begin
              state_d = IDLE;
              div_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc[RATIO_WD-1:0];
            div_d = (cnt_inc < half);
            if (load) begin
              shadow_d = slice;
              busy_d   = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst) begin
      if (!i_rst) begin
        state_q  <= IDLE;
        ratio_q  <= '0;
        shadow_q <= '0;
        busy_q   <= 1'b0;
        cnt_q    <= '0;
        div_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        ratio_q  <= ratio_d;
        shadow_q <= shadow_d;
        busy_q   <= busy_d;
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        tick_q   <= tick_d;
      end
    end

    // Bypass is a plain mux onto the reference clock.
    assign div_clk_w[k] = run ? div_q : i_ref_clk;
    assign tick_w[k]    = tick_q;
    assign busy_w[k]    = busy_q;
  end

  assign bus.o_div_clk    = div_clk_w;
  assign bus.o_rise_tick  = tick_w;
  assign bus.o_ratio_busy = busy_w;

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, run-time reprogrammable integer clock divider for the UART/peripheral clocking path. It generates NUM_CH independent divided clocks from one reference clock. Each channel has a shadowed division ratio that is applied only at a period boundary, so a ratio change never produces a short or runt pulse. Each channel also produces a registered rising-edge strobe, so downstream logic can use it as a clock-enable instead of a derived clock.

## Interface
- NUM_CH, 2: number of independent divider channels (≥1).
- RATIO_WD, 8: division-ratio width; legal ratios 0..2^RATIO_WD-1.
- i_ref_clk  in  1  reference clock; all state on its rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_clk_en  in  NUM_CH  per-channel divider enable.
- i_div_ratio  in  NUM_CH*RATIO_WD  packed ratios; channel k at [k*RATIO_WD +: RATIO_WD].
- i_ratio_load  in  NUM_CH  per-channel single-cycle strobe that captures that channel's i_div_ratio slice.
- o_div_clk  out  NUM_CH  divided clock, or i_ref_clk when bypassed.
- o_rise_tick  out  NUM_CH  registered 1-cycle strobe, high in the ref cycle in which o_div_clk rises.
- o_ratio_busy  out  NUM_CH  a loaded ratio is pending and not yet active.

## Operation
- Per-channel state: active ratio R, shadow S, busy flag, counter cnt (RATIO_WD bits), div_q, tick_q.
- run = i_clk_en[k] && (R ≥ 2).
- bypass = !run.
- o_div_clk[k] = run ? div_q : i_ref_clk. This is a combinational select.
- High-phase length H = (R+1)>>1, computed at RATIO_WD+1 bits to avoid overflow.
  - Even R: 50% duty.
  - Odd R: high for one cycle longer than low.
- FSM has two states, IDLE and RUN.
- IDLE (run=0):
  - cnt=0, div_q=0, tick_q=0.
  - On the edge where run becomes 1: go to RUN with cnt←0, div_q←1, tick_q←1. The first high phase starts immediately.
- RUN:
  - When cnt==R-1 (wrap): cnt←0, div_q←1, tick_q←1. If busy: R←S and busy←0.
  - Otherwise: cnt←cnt+1, div_q←(cnt+1 < H), tick_q←0.
- RUN → IDLE:
  - The transition is immediate on the edge where i_clk_en[k] is sampled low; cnt, div_q and tick_q are cleared.
  - If the ratio applied at a wrap is <2, the next state is IDLE (bypass).
- Ratio load (i_ratio_load[k]=1):
  - In IDLE: R←slice directly, busy stays 0.
  - In RUN with no wrap this cycle: S←slice, busy←1.
  - In RUN on a wrap cycle: R←slice directly, busy←0. The load takes priority over an older S.
  - While busy: S is overwritten and the last load wins.
- Disable while busy: on that edge R←S, busy←0.
- i_div_ratio is ignored except when i_ratio_load is high. Channels are fully independent.

## Timing
- Reset (asynchronous assert, synchronous release): R=0, S=0, busy=0, cnt=0, div_q=0, tick_q=0, state IDLE.
  - Outputs during reset: o_div_clk=i_ref_clk (bypass), o_rise_tick=0, o_ratio_busy=0.
- Period in RUN is exactly R ref cycles. The first rise occurs 1 ref edge after run is sampled high.
- o_rise_tick is registered and aligned with the div_q rising transition (same edge). It is exactly 1 cycle wide, once per period.
- A ratio change takes effect at the first wrap after the load. The old period always completes.
- o_ratio_busy rises 1 edge after the load and falls on the wrap edge.
- Reset mid-period: immediate clear to the reset values. No partial pulse is held.

## Test plan
- Reset then bypass: i_rst=0 → o_div_clk follows i_ref_clk; tick=0, busy=0. Release, load R=1 → still bypass.
- Even ratio: load R=4, en=1 → period 4 cycles, 2 high / 2 low. Tick every 4th cycle, aligned with the rise; first rise 1 edge after en.
- Odd ratio and max: load R=5 → 3 high / 2 low. Load R=255 (RATIO_WD=8) → 128 high / 127 low, no counter overflow.
- Glitch-free change: running R=6, load R=3 at cnt=1.
  - busy is high until the wrap.
  - The current 6-cycle period completes, followed by 3-cycle periods.
  - No high or low phase shorter than 1 cycle or longer than the old phase.
- Load collisions:
  - Load 8 then 10 while busy → 10 applied at the wrap.
  - Load 4 exactly on the wrap cycle → 4 applied immediately, busy never asserts.
  - Load 0 while running → channel enters bypass at the wrap.
- Independence and abort:
  - NUM_CH=2 with ch0 R=2 and ch1 R=7 running concurrently; deassert ch1 en mid-period with a pending load → ch1 bypasses, R←S, busy←0, and ch0 is unaffected.
  - Assert i_rst mid-period → all channels return to the reset values at once.
